operand_b_pipe: RTL and testbench
=================================

OPERAND_B_PIPE -- requirements
Module: operand_b_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the data width of the operand path in bits; legal range is 2 to 64.
REQ-002 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port in_valid, input, 1 bit, indicates that the upstream operand is valid.
REQ-005 Port in_ready, output, 1 bit, indicates that the block accepts an operand this cycle.
REQ-006 Port in_b, input, WIDTH bits, is the raw B operand.
REQ-007 Port in_mode, input, 2 bits, selects conditioning: 00 pass, 01 invert, 10 negate, 11 zero.
REQ-008 Port out_valid, output, 1 bit, indicates that the conditioned operand is valid.
REQ-009 Port out_ready, input, 1 bit, indicates that the downstream ALU accepts the operand.
REQ-010 Port out_b, output, WIDTH bits, is the conditioned operand.
REQ-011 Port out_cin, output, 1 bit, is the adder carry-in that accompanies out_b.
REQ-012 Port out_zero, output, 1 bit, is 1 when out_b equals all-zeros.
REQ-013 Port out_neg, output, 1 bit, equals out_b[WIDTH-1].

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-015 Conditioning SHALL be applied at capture and SHALL produce the following {b, cin} pairs: pass gives {in_b, 0}; invert gives {~in_b, 0}; negate gives {~in_b, 1}; zero gives {0, 0}.
REQ-016 Each stored entry SHALL hold the conditioned b, cin, zero flag and neg flag; the flags are computed on the conditioned b, not on any downstream sum.
REQ-017 Storage SHALL consist of one output register plus one skid register, tracked by three states: EMPTY, ONE and FULL.
REQ-018 In EMPTY with an input transfer, the entry SHALL load into the output register and the state SHALL move to ONE; latency from input transfer to out_valid is 1 cycle.
REQ-019 In ONE with an input transfer and an output transfer in the same cycle, the new entry SHALL replace the output register and the state SHALL remain ONE.
REQ-020 In ONE with an output transfer only, the state SHALL move to EMPTY.
REQ-021 In ONE with an input transfer only, the entry SHALL load into the skid register and the state SHALL move to FULL.
REQ-022 In FULL with an output transfer, the skid entry SHALL move to the output register and the state SHALL move to ONE.
REQ-023 in_ready SHALL be a registered output equal to 1 in EMPTY and ONE and equal to 0 in FULL; the block SHALL ignore in_valid while in FULL.
REQ-024 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-025 While out_valid=1 and out_ready=0, out_b, out_cin, out_zero and out_neg SHALL hold stable.
REQ-026 Entries SHALL leave in the order accepted; no entry may be dropped or duplicated.
REQ-027 in_mode SHALL be sampled only on an input transfer; mode changes at any other time SHALL have no effect.
REQ-028 At maximum rate (in_valid=1 and out_ready=1 on every cycle), the block SHALL sustain one transfer per cycle.

Reset
REQ-029 While rst=1, the state SHALL be EMPTY and in_ready, out_valid, out_b, out_cin, out_zero and out_neg SHALL all be 0.
REQ-030 in_ready SHALL rise to 1 on the first clock edge at which rst is sampled 0.
REQ-031 Reset asserted mid-operation SHALL discard both stored entries, with no output transfer occurring in that cycle.

Verification
REQ-032 Scenario: WIDTH=32; apply in_b=0x0000_0005 in each of the four modes with out_ready=1 -> out_b/out_cin = 0x0000_0005/0, 0xFFFF_FFFA/0, 0xFFFF_FFFA/1 and 0x0000_0000/0 respectively, with out_neg=1 for modes 01 and 10 and out_zero=1 for mode 11, each appearing one cycle after its input transfer.
REQ-033 Scenario: hold out_ready=0 and offer three entries A, B, C -> A and B are accepted, in_ready=0 from the cycle after B is accepted, C is held upstream, and out_b remains A.
REQ-034 Scenario: from FULL, raise out_ready for 3 cycles while C is still offered -> A, B and C emerge in that order with no gaps and no duplicates.
REQ-035 Scenario: continuous in_valid=1 and out_ready=1 for 100 random entries -> 100 outputs, in order, matching the reference model, with throughput of 1 per cycle.
REQ-036 Scenario: assert rst for 1 cycle while in FULL -> out_valid=0 and in_ready=0 during reset, in_ready=1 on the next cycle, and neither stored entry is ever emitted.
REQ-037 Scenario: WIDTH=4; negate mode with in_b=0x0 -> out_b=0xF, out_cin=1, out_zero=0 and out_neg=1.

Source files
------------

// File: rtl/operand_b_pipe.sv
`default_nettype none
// ============================================================================
// Module   : operand_b_pipe
// Purpose  : Conditions the ALU B operand (pass / invert / negate / zero) at
//            capture and buffers it through a two-entry output+skid stage
//            with valid/ready handshakes on both sides.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - upstream handshake (in_ready is registered)
//            in_b, in_mode   - raw operand, mode 00 pass/01 inv/10 neg/11 zero
//            out_valid/ready - downstream handshake
//            out_b, out_cin  - conditioned operand and adder carry-in
//            out_zero/neg    - flags of the conditioned operand
// Revision : 1.0 - initial release
// ============================================================================
module operand_b_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_cin,
  output logic             out_zero,
  output logic             out_neg
);

  localparam logic [1:0] c_MODE_PASS = 2'b00;
  localparam logic [1:0] c_MODE_INV  = 2'b01;
  localparam logic [1:0] c_MODE_NEG  = 2'b10;
  localparam logic [1:0] c_MODE_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   in_ready_q;

  logic [WIDTH-1:0] out_b_q,  skid_b_q;
  logic             out_cin_q, skid_cin_q;
  logic             out_zero_q, skid_zero_q;
  logic             out_neg_q,  skid_neg_q;

  logic [WIDTH-1:0] w_cond_b;
  logic             w_cond_cin;
  logic             w_cond_zero;
  logic             w_cond_neg;

  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_out_new;
  logic w_ld_out_skid;
  logic w_ld_skid;

  // Conditioning happens on the way in so stored entries already carry
  // their flags; negate is expressed as ~b with carry-in 1 for the adder.
  always_comb begin
    w_cond_b   = in_b;
    w_cond_cin = 1'b0;
    case (in_mode)
      c_MODE_PASS: begin
        w_cond_b   = in_b;
        w_cond_cin = 1'b0;
      end
      c_MODE_INV: begin
        w_cond_b   = ~in_b;
        w_cond_cin = 1'b0;
      end
      c_MODE_NEG: begin
        w_cond_b   = ~in_b;
        w_cond_cin = 1'b1;
      end
      c_MODE_ZERO: begin
        w_cond_b   = '0;
        w_cond_cin = 1'b0;
      end
      default: begin
        w_cond_b   = in_b;
        w_cond_cin = 1'b0;
      end
    endcase
    w_cond_zero = (w_cond_b == '0);
    w_cond_neg  = w_cond_b[WIDTH-1];
  end

  assign out_valid  = (state_q != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready_q;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    w_ld_out_new  = 1'b0;
    w_ld_out_skid = 1'b0;
    w_ld_skid     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_ld_out_new = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_out_new = 1'b1;
        end else if (w_out_fire) begin
          state_d = ST_EMPTY;
        end else if (w_in_fire) begin
          w_ld_skid = 1'b1;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no capture can happen in this state.
        if (w_out_fire) begin
          w_ld_out_skid = 1'b1;
          state_d       = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_b_q     <= '0;
      out_cin_q   <= 1'b0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      skid_b_q    <= '0;
      skid_cin_q  <= 1'b0;
      skid_zero_q <= 1'b0;
      skid_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Registered ready: look ahead at the next state so the skid slot
      // is never overrun.
      in_ready_q <= (state_d != ST_FULL);
      if (w_ld_out_new) begin
        out_b_q    <= w_cond_b;
        out_cin_q  <= w_cond_cin;
        out_zero_q <= w_cond_zero;
        out_neg_q  <= w_cond_neg;
      end else if (w_ld_out_skid) begin
        out_b_q    <= skid_b_q;
        out_cin_q  <= skid_cin_q;
        out_zero_q <= skid_zero_q;
        out_neg_q  <= skid_neg_q;
      end
      if (w_ld_skid) begin
        skid_b_q    <= w_cond_b;
        skid_cin_q  <= w_cond_cin;
        skid_zero_q <= w_cond_zero;
        skid_neg_q  <= w_cond_neg;
      end
    end
  end

  assign in_ready = in_ready_q;
  assign out_b    = out_b_q;
  assign out_cin  = out_cin_q;
  assign out_zero = out_zero_q;
  assign out_neg  = out_neg_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_b_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_b_pipe
// Purpose  : Self-checking bench for operand_b_pipe (WIDTH=32 and WIDTH=4).
//            The reference is a two-deep FIFO of conditioned entries computed
//            with plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_b_pipe;

  typedef struct {
    logic [63:0] b;
    logic        cin;
    logic        zero;
    logic        neg;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_b, out_b;
  logic [1:0]  in_mode;
  logic        out_cin, out_zero, out_neg;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  in_b4, out_b4;
  logic [1:0]  in_mode4;
  logic        out_cin4, out_zero4, out_neg4;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_obs_out = 0;
  ent_t q[$];
  logic rdy_en;
  logic zero_exp;

  always #5 clk = ~clk;

  operand_b_pipe #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b),
    .out_cin(out_cin), .out_zero(out_zero), .out_neg(out_neg)
  );

  operand_b_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_b(in_b4), .in_mode(in_mode4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_b(out_b4),
    .out_cin(out_cin4), .out_zero(out_zero4), .out_neg(out_neg4)
  );

  // Reference conditioning for a 32-bit operand using integer arithmetic.
  function automatic ent_t cond(input logic [31:0] b, input logic [1:0] m);
    ent_t e;
    longint unsigned all_ones = 64'h0000_0000_FFFF_FFFF;
    e.b   = 64'd0;
    e.cin = 1'b0;
    if (m == 2'd0) e.b = {32'd0, b};
    else if (m == 2'd1) e.b = all_ones - {32'd0, b};
    else if (m == 2'd2) begin
      e.b   = all_ones - {32'd0, b};
      e.cin = 1'b1;
    end else e.b = 64'd0;
    e.zero = (e.b == 64'd0);
    e.neg  = (e.b >= 64'h0000_0000_8000_0000);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check current outputs against the model, apply inputs,
  // advance the model by the transfers that happen at the coming edge.
  task automatic step(input logic r, input logic iv, input logic [31:0] b,
                      input logic [1:0] m, input logic ordy);
    ent_t h;
    logic in_fire;
    chk("in_ready", {63'd0, in_ready}, {63'd0, (rdy_en && (q.size() < 2))});
    chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      h = q[0];
      chk("out_b", {32'd0, out_b}, h.b);
      chk("out_cin", {63'd0, out_cin}, {63'd0, h.cin});
      chk("out_zero", {63'd0, out_zero}, {63'd0, h.zero});
      chk("out_neg", {63'd0, out_neg}, {63'd0, h.neg});
    end else if (zero_exp) begin
      chk("rst out_b", {32'd0, out_b}, 64'd0);
      chk("rst flags", {61'd0, out_cin, out_zero, out_neg}, 64'd0);
    end
    rst = r; in_valid = iv; in_b = b; in_mode = m; out_ready = ordy;
    if (out_valid && ordy && !r) n_obs_out++;
    if (r) begin
      q.delete();
      rdy_en   = 1'b0;
      zero_exp = 1'b1;
    end else begin
      in_fire = iv && rdy_en && (q.size() < 2);
      if (ordy && (q.size() > 0)) void'(q.pop_front());
      if (in_fire) begin
        q.push_back(cond(b, m));
        zero_exp = 1'b0;
      end
      rdy_en = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; in_b = '0; in_mode = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_b4 = '0; in_mode4 = '0; out_ready4 = 1'b0;
    rdy_en = 1'b0; zero_exp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then release.
    chk("rst in_ready4", {63'd0, in_ready4}, 64'd0);
    chk("rst out_valid4", {63'd0, out_valid4}, 64'd0);
    step(1'b1, 1'b0, 32'd0, 2'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 2'd0, 1'b0);
    chk("ready after rst", {63'd0, in_ready}, 64'd1);

    // Four modes on 5, one per cycle; WIDTH=4 negate of 0 alongside.
    in_valid4 = 1'b1; in_b4 = 4'h0; in_mode4 = 2'b10; out_ready4 = 1'b1;
    step(1'b0, 1'b1, 32'd5, 2'd0, 1'b1);
    in_valid4 = 1'b0;
    chk("w4 out_b", {60'd0, out_b4}, 64'hF);
    chk("w4 flags", {60'd0, out_valid4, out_cin4, out_zero4, out_neg4}, 64'b1101);
    chk("m00 b", {32'd0, out_b}, 64'h0000_0005);
    chk("m00 cin/z/n", {61'd0, out_cin, out_zero, out_neg}, 64'b000);
    step(1'b0, 1'b1, 32'd5, 2'd1, 1'b1);
    chk("m01 b", {32'd0, out_b}, 64'hFFFF_FFFA);
    chk("m01 cin/z/n", {61'd0, out_cin, out_zero, out_neg}, 64'b001);
    step(1'b0, 1'b1, 32'd5, 2'd2, 1'b1);
    chk("m10 b", {32'd0, out_b}, 64'hFFFF_FFFA);
    chk("m10 cin/z/n", {61'd0, out_cin, out_zero, out_neg}, 64'b101);
    step(1'b0, 1'b1, 32'd5, 2'd3, 1'b1);
    chk("m11 b", {32'd0, out_b}, 64'h0);
    chk("m11 cin/z/n", {61'd0, out_cin, out_zero, out_neg}, 64'b010);
    step(1'b0, 1'b0, 32'd0, 2'd0, 1'b1);

    // Back-pressure: A and B accepted, C held upstream, out_b stays A.
    step(1'b0, 1'b1, 32'hAAAA_0001, 2'd0, 1'b0);
    step(1'b0, 1'b1, 32'hBBBB_0002, 2'd1, 1'b0);
    chk("full in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b0, 1'b1, 32'hCCCC_0003, 2'd2, 1'b0);
    step(1'b0, 1'b1, 32'hCCCC_0003, 2'd3, 1'b0);
    chk("hold out_b", {32'd0, out_b}, 64'hAAAA_0001);
    // Drain with C still offered until it is accepted (mode change on a
    // non-transfer cycle above must have no effect).
    step(1'b0, 1'b1, 32'hCCCC_0003, 2'd2, 1'b1);
    chk("drain B", {32'd0, out_b}, 64'h4444_FFFD);
    step(1'b0, 1'b1, 32'hCCCC_0003, 2'd2, 1'b1);
    chk("drain C", {32'd0, out_b}, 64'h3333_FFFC);
    chk("drain C cin", {63'd0, out_cin}, 64'd1);
    step(1'b0, 1'b0, 32'd0, 2'd0, 1'b1);
    chk("drained", {63'd0, out_valid}, 64'd0);

    // Full-rate random stream.
    base = n_obs_out;
    for (int i = 0; i < 100; i++)
      step(1'b0, 1'b1, $urandom, 2'($urandom_range(0, 3)), 1'b1);
    step(1'b0, 1'b0, 32'd0, 2'd0, 1'b1);
    chk("throughput", 64'(n_obs_out - base), 64'd100);

    // Mixed random traffic with random back-pressure.
    for (int i = 0; i < 200; i++)
      step(1'b0, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 2'd0, 1'b1);

    // Reset while FULL: both entries discarded.
    step(1'b0, 1'b1, 32'h1234_5678, 2'd0, 1'b0);
    step(1'b0, 1'b1, 32'h8765_4321, 2'd0, 1'b0);
    chk("pre-rst full", {63'd0, in_ready}, 64'd0);
    step(1'b1, 1'b1, 32'h0, 2'd0, 1'b1);
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b0, 1'b0, 32'd0, 2'd0, 1'b1);
    chk("post-rst in_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 2'd0, 1'b1);
    chk("no stale emit", {63'd0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
